// File: rtl/uart_cmd_master.sv
// uart_cmd_master: register read/write command master over a byte-wide UART link
module uart_cmd_master #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_BYTES = 2,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_rw,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_BYTES*8-1:0] req_wdata,
  output logic                    rsp_valid,
  output logic [DATA_BYTES*8-1:0] rsp_rdata,
  output logic [1:0]              rsp_status,
  output logic [7:0]              tx_data,
  output logic                    tx_en,
  input  logic                    tx_busy,
  input  logic [7:0]              rx_data,
  input  logic                    rx_data_valid,
  input  logic                    rx_error,
  output logic                    busy
);
  localparam int DW = DATA_BYTES * 8;
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [2:0] {IDLE, SEND, GAP, WAIT_RSP, DONE} state_t;
  state_t state, state_n;
  logic rw_q;
  logic [7:0] addr_q;
  logic [DW-1:0] wdata_q, shadow, sh_next;
  logic [2:0] idx, rx_cnt, n_bytes;
  logic [CW-1:0] cnt;
  logic [7:0] frame_byte;
  logic frame_end, last_byte, timeout;
  assign n_bytes = rw_q ? 3'd2 : 3'(DATA_BYTES + 2);
  assign frame_end = idx == n_bytes;
  assign sh_next = (shadow << 8) | DW'(rx_data);
  assign last_byte = rx_data_valid && rx_cnt == 3'(DATA_BYTES - 1);
  assign timeout = !rx_data_valid && cnt == CW'(TIMEOUT_CYC - 2);
  assign frame_byte = idx == 3'd0 ? (rw_q ? 8'h52 : 8'h57) : idx == 3'd1 ? addr_q : wdata_q[DW-1 -: 8];
  assign req_ready = state == IDLE;
  assign busy = state != IDLE;
  assign rsp_valid = state == DONE;
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = req_valid ? SEND : IDLE;
      SEND:     state_n = tx_busy ? SEND : GAP;
      GAP:      state_n = !frame_end ? SEND : rw_q ? WAIT_RSP : DONE;
      WAIT_RSP: state_n = (rx_error || last_byte || timeout) ? DONE : WAIT_RSP;
      default:  state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rw_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      shadow <= '0;
      idx <= '0;
      rx_cnt <= '0;
      cnt <= '0;
      tx_en <= 1'b0;
      tx_data <= '0;
      rsp_rdata <= '0;
      rsp_status <= 2'b00;
    end else begin
      tx_en <= 1'b0;
      if (state == IDLE && req_valid) begin
        rw_q <= req_rw;
        addr_q <= 8'(req_addr);
        wdata_q <= req_wdata;
        idx <= '0;
      end
      if (state == SEND && !tx_busy) begin
        tx_en <= 1'b1;
        tx_data <= frame_byte;
        idx <= idx + 3'd1;
        if (idx >= 3'd2) wdata_q <= wdata_q << 8;
      end
      if (state == GAP) begin
        cnt <= '0;
        rx_cnt <= '0;
        if (frame_end && !rw_q) rsp_status <= 2'b00;
      end
      if (state == WAIT_RSP) begin
        if (rx_error) begin
          rsp_rdata <= '0;
          rsp_status <= 2'b10;
        end else if (rx_data_valid) begin
          cnt <= '0;
          rx_cnt <= rx_cnt + 3'd1;
          shadow <= sh_next;
          if (last_byte) begin
            rsp_rdata <= sh_next;
            rsp_status <= 2'b00;
          end
        end else begin
          cnt <= cnt + 1'b1;
          if (timeout) begin
            rsp_rdata <= '0;
            rsp_status <= 2'b01;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_cmd_master.sv
// tb_uart_cmd_master: randomized scoreboard bench for uart_cmd_master
module tb_uart_cmd_master;
  localparam int AW = 8, DB = 2, DW = DB * 8, TO = 50;
  logic clk = 0, reset = 1, req_valid = 0, req_rw = 0, rx_data_valid = 0, rx_error = 0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0, rsp_rdata;
  logic [7:0] rx_data = '0, tx_data;
  logic req_ready, rsp_valid, tx_en, tx_busy, busy;
  logic [1:0] rsp_status;
  typedef struct {logic [1:0] st; logic [DW-1:0] rd; bit rel_rx; int dly;} exp_t;
  logic [7:0] exp_tx[$];
  exp_t exp_rsp[$];
  int n_cmp = 0, n_err = 0, cyc = 0, last_tx_cyc = 0, last_rx_cyc = 0, busy_cnt = 0;
  logic [DW-1:0] committed = '0, model_rd = '0;
  logic prev_tx_en = 0;

  uart_cmd_master #(.ADDR_WIDTH(AW), .DATA_BYTES(DB), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_status(rsp_status), .tx_data(tx_data), .tx_en(tx_en), .tx_busy(tx_busy),
    .rx_data(rx_data), .rx_data_valid(rx_data_valid), .rx_error(rx_error), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) busy_cnt <= reset ? 0 : tx_en ? 10 : busy_cnt > 0 ? busy_cnt - 1 : 0;
  assign tx_busy = busy_cnt != 0;

  task automatic chk(string name, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: event occurred, required none (cycle %0d)", name, cyc);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && !rsp_valid) chk("rdata_hold", rsp_rdata, committed);
    if (tx_en) begin
      chk("tx_en_while_busy", tx_busy, 0);
      chk("tx_en_consecutive", prev_tx_en, 0);
      if (exp_tx.size() == 0) flag("tx_unexpected");
      else chk("tx_byte", tx_data, exp_tx.pop_front());
      last_tx_cyc = cyc;
    end
    if (rx_data_valid || rx_error) last_rx_cyc = cyc;
    if (!reset && req_valid && req_ready) chk("accept_while_outstanding", exp_rsp.size(), 0);
    if (rsp_valid) begin
      if (exp_rsp.size() == 0) flag("rsp_unexpected");
      else begin
        e = exp_rsp.pop_front();
        chk("rsp_status", rsp_status, e.st);
        chk("rsp_rdata", rsp_rdata, e.rd);
        chk("rsp_latency", cyc - (e.rel_rx ? last_rx_cyc : last_tx_cyc), e.dly);
        committed = e.rd;
      end
    end
    prev_tx_en = tx_en;
  end

  task automatic issue(input bit rw, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input int mode, input logic [DW-1:0] rd, input bit hold);
    exp_t e;
    int t = 0;
    req_rw = rw;
    req_addr = a;
    req_wdata = wd;
    req_valid = 1;
    exp_tx.push_back(rw ? 8'h52 : 8'h57);
    exp_tx.push_back(8'(a));
    if (!rw) for (int i = DB - 1; i >= 0; i--) exp_tx.push_back(wd[i*8 +: 8]);
    do begin @(negedge clk); t++; end while (!req_ready && t < 3000);
    if (!req_ready) flag("accept_timeout");
    @(posedge clk); #1;
    if (!hold) req_valid = 0;
    if (rw) model_rd = mode == 0 ? rd : '0;
    e.st = !rw ? 2'b00 : mode == 1 ? 2'b01 : mode == 2 ? 2'b10 : 2'b00;
    e.rd = model_rd;
    e.rel_rx = rw;
    e.dly = (rw && mode == 1) ? TO : 1;
    exp_rsp.push_back(e);
  endtask

  task automatic strobe(input bit v, input bit er, input logic [7:0] d, input int gap);
    repeat (gap) begin @(posedge clk); #1; end
    rx_data = d;
    rx_data_valid = v;
    rx_error = er;
    @(posedge clk); #1;
    rx_data_valid = 0;
    rx_error = 0;
  endtask

  task automatic respond(input int mode, input logic [DW-1:0] rd);
    int t = 0;
    do begin @(posedge clk); t++; end while (exp_tx.size() != 0 && t < 3000);
    #1;
    if (exp_tx.size() != 0) flag("tx_frame_timeout");
    if (mode == 0) for (int i = DB - 1; i >= 0; i--) strobe(1, 0, rd[i*8 +: 8], $urandom_range(0, 3));
    else if (mode == 1) strobe(1, 0, 8'($urandom), $urandom_range(0, 3));
    else begin
      repeat ($urandom_range(0, DB - 1)) strobe(1, 0, 8'($urandom), $urandom_range(0, 3));
      strobe(1, 1, 8'($urandom), $urandom_range(0, 3));
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while (exp_rsp.size() != 0 && t < 3000) begin @(posedge clk); t++; end
    if (exp_rsp.size() != 0) begin
      flag("rsp_timeout");
      exp_rsp.delete();
      exp_tx.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic op(input bit rw, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                    input int mode, input logic [DW-1:0] rd);
    issue(rw, a, wd, mode, rd, 0);
    if (rw) respond(mode, rd);
    wait_idle();
  endtask

  task automatic strays();
    repeat ($urandom_range(1, 4)) strobe(1, 1'($urandom), 8'($urandom), $urandom_range(0, 2));
  endtask

  initial begin
    int t, r;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_tx_en", tx_en, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_status", rsp_status, 0);
    @(posedge clk); #1;
    reset = 0;
    op(0, 8'h05, 16'hA55A, 0, '0);
    op(1, 8'h10, '0, 0, 16'h1234);
    op(1, 8'h44, '0, 1, '0);
    op(1, 8'h22, '0, 2, '0);
    op(1, 8'h23, '0, 0, 16'hCAFE);
    strays();
    op(0, 8'h66, 16'h0F0F, 0, '0);
    issue(0, 8'h33, 16'hBEEF, 0, '0, 0);
    t = 0;
    while (exp_tx.size() > DB && t < 3000) begin @(posedge clk); t++; end
    #1;
    reset = 1;
    exp_tx.delete();
    exp_rsp.delete();
    committed = '0;
    model_rd = '0;
    repeat (2) begin @(posedge clk); #1; end
    reset = 0;
    @(negedge clk);
    chk("post_rst_req_ready", req_ready, 1);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_rsp_rdata", rsp_rdata, 0);
    @(posedge clk); #1;
    op(0, 8'h34, 16'h1357, 0, '0);
    op(1, 8'h35, '0, 0, 16'h8001);
    issue(0, 8'h71, 16'h1111, 0, '0, 1);
    issue(0, 8'h72, 16'h2222, 0, '0, 0);
    wait_idle();
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      op(1'($urandom), AW'($urandom), DW'($urandom), r < 7 ? 0 : r < 9 ? 2 : 1, DW'($urandom));
      if ($urandom_range(0, 2) == 0) strays();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end
endmodule
